// File: rtl/hbintfifo.sv
// Response buffer between the bus executor and the idle/deword stages.
// First-word-fall-through queue that also inserts interrupt and overflow marker words.
module hbintfifo #(
  parameter int            LGFLEN   = 4,
  parameter int            W        = 34,
  parameter logic [W-1:0]  INT_WORD = 34'h3_0000_0000,
  parameter logic [W-1:0]  OVF_WORD = 34'h3_4000_0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_interrupt,
  input  logic              i_stb,
  input  logic [W-1:0]      i_word,
  output logic              o_busy,
  output logic              o_stb,
  output logic [W-1:0]      o_word,
  input  logic              i_busy,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_overflow
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FULL_FILL = (LGFLEN+1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [LGFLEN-1:0] wr_ptr, rd_ptr;
  logic [LGFLEN:0]   fill;
  logic              int_last, int_pending, ovf_pending;

  logic              full, pop, room, int_edge;
  logic              wr_en, wr_ovf, wr_int, drop;
  logic [W-1:0]      wr_data;

  assign full     = (fill == FULL_FILL);
  assign o_stb    = (fill != '0);
  assign pop      = o_stb && !i_busy;
  // A pop frees its slot in the same cycle, so a full queue can still accept.
  assign room     = !full || pop;
  assign o_busy   = ovf_pending || (full && !pop);
  assign int_edge = i_interrupt && !int_last;
  assign drop     = i_stb && o_busy;

  always_comb begin
    wr_en   = 1'b0;
    wr_ovf  = 1'b0;
    wr_int  = 1'b0;
    wr_data = '0;
    if (room) begin
      if (ovf_pending) begin
        wr_en   = 1'b1;
        wr_ovf  = 1'b1;
        wr_data = OVF_WORD;
      end else if (i_stb) begin
        wr_en   = 1'b1;
        wr_data = i_word;
      end else if (int_pending) begin
        wr_en   = 1'b1;
        wr_int  = 1'b1;
        wr_data = INT_WORD;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      int_last    <= 1'b0;
      int_pending <= 1'b0;
      ovf_pending <= 1'b0;
    end else begin
      int_last    <= i_interrupt;
      // An edge arriving while INT_WORD is written keeps the request alive.
      int_pending <= (int_pending && !wr_int) || int_edge;
      ovf_pending <= (ovf_pending && !wr_ovf) || drop;
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  assign o_word     = o_stb ? mem[rd_ptr] : '0;
  assign o_fill     = fill;
  assign o_overflow = ovf_pending;

endmodule
